// File: rtl/hex_display_pkg.sv
// Shared constants and the active-low seven-segment decode table for the
// hex display blocks.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         NUM_DIGITS = 8;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-segment decoder, shared with the single-digit labs.
module hex_to_seg
  import hex_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex2seg(hex);

endmodule

// File: rtl/hex_scan_display.sv
// Eight-digit multiplexed hex display; updates are staged and swapped into
// the shadow frame only at the digit 7 -> 0 boundary so frames never tear.
module hex_scan_display
  import hex_display_pkg::*;
#(
  parameter int DIGIT_PERIOD_CYC = 50000
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  mask_i,
  input  logic [7:0]  dp_i,
  input  logic        upd_i,
  output logic        busy_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int              CNT_W   = (DIGIT_PERIOD_CYC > 1) ? $clog2(DIGIT_PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_PERIOD_CYC - 1);

  logic [CNT_W-1:0] tick_cnt_r;
  logic [2:0]       idx_r;
  logic [31:0]      stage_data_r;
  logic [7:0]       stage_mask_r;
  logic [7:0]       stage_dp_r;
  logic             pending_r;
  logic [31:0]      shadow_data_r;
  logic [7:0]       shadow_mask_r;
  logic [7:0]       shadow_dp_r;
  logic [7:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;

  logic             tick_s;
  logic             swap_s;
  logic [3:0]       nibble_s;
  logic [6:0]       dec_seg_s;
  logic [7:0]       an_nxt_s;
  logic [6:0]       seg_nxt_s;
  logic             dp_nxt_s;

  assign tick_s   = (tick_cnt_r == CNT_MAX);
  assign swap_s   = tick_s && (idx_r == 3'd7) && pending_r;
  assign nibble_s = shadow_data_r[{idx_r, 2'b00} +: 4];

  // Digit dwell counter; tick marks the last cycle of each digit.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + CNT_W'(1);
    end
  end

  // Scan index advances once per digit period, wrapping 7 -> 0.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      idx_r <= 3'd0;
    end else if (tick_s) begin
      idx_r <= idx_r + 3'd1;
    end
  end

  // Staging capture; a new strobe always wins over a simultaneous swap.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stage_data_r <= 32'h0;
      stage_mask_r <= 8'h00;
      stage_dp_r   <= 8'h00;
      pending_r    <= 1'b0;
    end else begin
      if (upd_i) begin
        stage_data_r <= data_i;
        stage_mask_r <= mask_i;
        stage_dp_r   <= dp_i;
      end
      if (upd_i) begin
        pending_r <= 1'b1;
      end else if (swap_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Shadow frame loads from staging only at the frame boundary.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      shadow_data_r <= 32'h0;
      shadow_mask_r <= 8'h00;
      shadow_dp_r   <= 8'h00;
    end else if (swap_s) begin
      shadow_data_r <= stage_data_r;
      shadow_mask_r <= stage_mask_r;
      shadow_dp_r   <= stage_dp_r;
    end
  end

  hex_to_seg u_dec (
    .hex (nibble_s),
    .seg (dec_seg_s)
  );

  // Next output pattern for the digit currently selected by idx.
  always_comb begin
    an_nxt_s  = 8'hFF;
    seg_nxt_s = SEG_BLANK;
    dp_nxt_s  = 1'b1;
    if (shadow_mask_r[idx_r]) begin
      an_nxt_s  = ~(8'b1 << idx_r);
      seg_nxt_s = dec_seg_s;
      dp_nxt_s  = ~shadow_dp_r[idx_r];
    end else begin
      an_nxt_s  = 8'hFF;
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b1;
    end
  end

  // Output flops keep the pins glitch-free.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      an_r  <= 8'hFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
    end
  end

  assign an_o   = an_r;
  assign seg_o  = seg_r;
  assign dp_o   = dp_r;
  assign busy_o = pending_r;

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Multiplexed 8-digit seven-segment driver that reads values produced by the counter datapath (switch data, event count) and shows them as hex on the board display. It sits on the output side of the lab design, opposite the switch/key input logic. A staged update handshake guarantees a full frame is never shown with mixed old and new digits.

## Interface
- `DIGIT_PERIOD_CYC`, default 50000: clk_i cycles each digit is lit (1 ms at 50 MHz). Must be ≥ 2.
- `clk_i`, input, 1: system clock, 50 MHz.
- `arstn_i`, input, 1: asynchronous, active-low reset.
- `data_i`, input, 32: eight hex nibbles. Nibble k maps to digit k; digit 0 is rightmost.
- `mask_i`, input, 8: digit enable. 0 blanks that digit.
- `dp_i`, input, 8: decimal point per digit, 1 = lit.
- `upd_i`, input, 1: single-cycle strobe that captures data_i, mask_i and dp_i into staging.
- `busy_o`, output, 1: staged value not yet shown (pending).
- `an_o`, output, 8: digit anodes, active-low, one-hot-low or all ones.
- `seg_o`, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp_o`, output, 1: decimal point, active-low.

## Operation
- Registers:
  - tick counter, 0..DIGIT_PERIOD_CYC-1.
  - digit index idx, 3 bits.
  - staging {data, mask, dp} and pending flag.
  - shadow {data, mask, dp}.
  - output registers.
- Reset values: all of these are 0, except an_o=8'hFF, seg_o=7'h7F, dp_o=1.
- Tick: the counter counts up every cycle. When it reaches DIGIT_PERIOD_CYC-1, it wraps to 0 and asserts tick for that cycle.
- Scan: on tick, idx ← idx+1, wrapping 7→0.
- Capture: when upd_i=1, staging ← inputs and pending ← 1.
- Frame swap: on tick with idx==7, if pending then shadow ← staging and pending ← 0. This happens on the same edge that idx becomes 0.
- If upd_i coincides with the swap edge:
  - the old staging goes to shadow;
  - staging takes the new inputs;
  - pending stays 1, because the new arrival wins.
- If upd_i arrives while pending=1, staging is overwritten and the last write wins. No error is raised.
- busy_o = pending, driven directly from the register.
- Output stage, registered every cycle from the current idx and shadow:
  - an_o = ~(8'b1 << idx) if shadow.mask[idx], else 8'hFF;
  - seg_o = hex decode of shadow.data[4*idx+3 -: 4], or 7'h7F when masked;
  - dp_o = ~shadow.dp[idx], or 1 when masked.
- Decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Reset mid-operation: everything returns to reset values immediately and asynchronously. Any pending update is discarded.

## Timing
- Outputs lag idx/shadow by exactly 1 cycle.
- First edge after reset release: outputs drive digit 0 from the zero shadow. Since mask=0, an_o remains FF.
- Each digit is lit for exactly DIGIT_PERIOD_CYC cycles.
- Frame period is 8·DIGIT_PERIOD_CYC cycles.
- Update latency, from upd_i to the new value first appearing on digit 0:
  - at most 8·DIGIT_PERIOD_CYC + 1 cycles;
  - at least 2 cycles, when upd_i lands one cycle before the swap edge.
- There are no glitches: an_o, seg_o and dp_o change only on clock edges, all from flops.

## Structure
- Package `hex_display_pkg`:
  - `SEG_BLANK` = 7'h7F;
  - `NUM_DIGITS` = 8;
  - function `hex2seg(logic [3:0]) → logic [6:0]` holding the decode table above.
- Sub-module `hex_to_seg`: a combinational wrapper around hex2seg. It is reusable by the single-digit labs.
- Top: tick counter, idx, staging/shadow, output flops. About 150 lines.

## Test plan
Benches use DIGIT_PERIOD_CYC=4 and a 50 MHz clock.

1. Reset: hold arstn_i low for 3 cycles → an_o=FF, seg_o=7F, dp_o=1, busy_o=0. Release, run 40 cycles, no upd_i → an_o stays FF.
2. Display `data_i`=32'h0000_03A5 with `mask_i`=8'h1F and `dp_i`=8'h04, pulse upd_i → busy_o=1 until the next idx 7→0 swap, then 0. In the next frame:
   - digit 0: an_o=FE, seg_o=12 (5);
   - digit 1: seg_o=08 (A);
   - digit 2: seg_o=30 (3) with dp_o=0;
   - digit 3: seg_o=40 (0);
   - digit 4: seg_o=40 (0);
   - digits 5–7: an_o=FF.
3. Two upd_i pulses within one frame (values 32'h1111_1111, then 32'h2222_2222), mask FF → only 2 is ever displayed on any digit. busy_o stays 1 until the swap.
4. upd_i on the exact swap edge with a new value, after an old value was pending → the old value shows in frame N, the new value in frame N+1, and busy_o stays 1 across the edge.
5. Pull arstn_i low mid-frame while pending=1 → outputs return to reset values within the same cycle and busy_o=0. The old shadow is not shown after release.
6. Dwell check: measure each an_o low period → exactly 4 cycles. The sequence FE, FD, FB, … 7F repeats, and only one bit of an_o is ever low at a time.
